// File: rtl/traffic_light_monitor.sv
// ============================================================================
// traffic_light_monitor: safety/sequence checker for a 3-approach lamp bus.
// Optional stall check is built only when TLM_TIMEOUT_EN is defined.
// Revision: 1.0
// ============================================================================
`default_nettype none

module traffic_light_monitor #(
  parameter int MIN_GREEN  = 2,
  parameter int MIN_YELLOW = 1,
  parameter int MAX_DWELL  = 16,
  parameter int CNT_W      = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             ENABLE,
  input  logic             CLR,
  input  logic             GA, YA, RA, LA,
  input  logic             GB, YB, RB, LB,
  input  logic             GC, YC, RC, LC,
  input  logic             RL, GL,
  input  logic             RR, GR,
  output logic [1:0]       PHASE,
  output logic             FAULT,
  output logic [2:0]       FAULT_CODE,
  output logic [CNT_W-1:0] CYCLES
);

  localparam logic [1:0] c_IDLE    = 2'd0;
  localparam logic [1:0] c_ARM     = 2'd1;
  localparam logic [1:0] c_RUN     = 2'd2;
  localparam logic [1:0] c_FAULTED = 2'd3;

  localparam logic [1:0] c_NONE = 2'd0;
  localparam logic [1:0] c_GRN  = 2'd1;
  localparam logic [1:0] c_YEL  = 2'd2;
  localparam logic [1:0] c_RED  = 2'd3;

  localparam logic [CNT_W-1:0] c_min_green  = CNT_W'(MIN_GREEN);
  localparam logic [CNT_W-1:0] c_min_yellow = CNT_W'(MIN_YELLOW);
  localparam logic [CNT_W-1:0] c_cnt_max    = {CNT_W{1'b1}};
`ifdef TLM_TIMEOUT_EN
  localparam logic [CNT_W-1:0] c_max_dwell  = CNT_W'(MAX_DWELL);
`endif

  logic [1:0]       r_state;
  logic [1:0]       r_col   [3];
  logic [CNT_W-1:0] r_dwell [3];
  logic [1:0]       r_phase;
  logic             r_fault;
  logic [2:0]       r_code;
  logic [CNT_W-1:0] r_cycles;

  logic [2:0]       w_g, w_y, w_r, w_l, w_nonred;
  logic [1:0]       w_col       [3];
  logic [CNT_W-1:0] w_dwell_nxt [3];
  logic             w_illegal, w_conflict, w_badseq, w_short_g, w_short_y;
  logic             w_ped_conf, w_stall;
  logic [2:0]       w_code;
  logic [1:0]       w_phase_nxt;
  logic             w_a_enter_g;

  assign w_g      = {GC, GB, GA};
  assign w_y      = {YC, YB, YA};
  assign w_r      = {RC, RB, RA};
  assign w_l      = {LC, LB, LA};
  assign w_nonred = w_g | w_y | w_l;

  always_comb begin
    w_illegal = !(RL ^ GL) || !(RR ^ GR);
    w_badseq  = 1'b0;
    w_short_g = 1'b0;
    w_short_y = 1'b0;
    w_stall   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      w_col[i] = w_g[i] ? c_GRN : w_y[i] ? c_YEL : w_r[i] ? c_RED : c_NONE;
      w_dwell_nxt[i] = (w_col[i] != r_col[i]) ? CNT_W'(1) :
                       (r_dwell[i] == c_cnt_max) ? r_dwell[i] : r_dwell[i] + 1'b1;
      if (!$onehot({w_g[i], w_y[i], w_r[i]}) || (w_l[i] && w_y[i]))
        w_illegal = 1'b1;
      if ((r_col[i] == c_GRN && w_col[i] == c_RED) ||
          (r_col[i] == c_RED && w_col[i] == c_YEL) ||
          (r_col[i] == c_YEL && w_col[i] == c_GRN))
        w_badseq = 1'b1;
      // Dwell checks use the count accumulated before this colour change.
      if (r_col[i] == c_GRN && w_col[i] == c_YEL && r_dwell[i] < c_min_green)
        w_short_g = 1'b1;
      if (r_col[i] == c_YEL && w_col[i] == c_RED && r_dwell[i] < c_min_yellow)
        w_short_y = 1'b1;
`ifdef TLM_TIMEOUT_EN
      if (w_dwell_nxt[i] >= c_max_dwell)
        w_stall = 1'b1;
`endif
    end
  end

  assign w_conflict  = !$onehot0(w_nonred);
  assign w_ped_conf  = (GL || GR) && (|w_nonred);
  assign w_a_enter_g = (r_col[0] == c_RED) && (w_col[0] == c_GRN);

  always_comb begin
    w_code = 3'd0;
    if      (w_illegal)  w_code = 3'd1;
    else if (w_conflict) w_code = 3'd2;
    else if (w_badseq)   w_code = 3'd3;
    else if (w_short_g)  w_code = 3'd4;
    else if (w_short_y)  w_code = 3'd5;
    else if (w_ped_conf) w_code = 3'd6;
    else if (w_stall)    w_code = 3'd7;
  end

  always_comb begin
    case (w_nonred)
      3'b000:  w_phase_nxt = 2'd0;
      3'b001:  w_phase_nxt = 2'd1;
      3'b010:  w_phase_nxt = 2'd2;
      3'b100:  w_phase_nxt = 2'd3;
      default: w_phase_nxt = r_phase;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state  <= c_IDLE;
      r_phase  <= 2'd0;
      r_fault  <= 1'b0;
      r_code   <= 3'd0;
      r_cycles <= '0;
      for (int i = 0; i < 3; i++) begin
        r_col[i]   <= c_NONE;
        r_dwell[i] <= '0;
      end
    end else if (CLR) begin
      r_state <= c_IDLE;
      r_fault <= 1'b0;
      r_code  <= 3'd0;
      for (int i = 0; i < 3; i++)
        r_dwell[i] <= '0;
    end else if (ENABLE) begin
      // Lamp tracking runs in every state so ARM starts from a valid history.
      for (int i = 0; i < 3; i++) begin
        r_col[i]   <= w_col[i];
        r_dwell[i] <= w_dwell_nxt[i];
      end
      r_phase <= w_phase_nxt;
      if (w_a_enter_g && r_cycles != c_cnt_max)
        r_cycles <= r_cycles + 1'b1;
      case (r_state)
        c_IDLE: r_state <= c_ARM;
        c_ARM:  r_state <= c_RUN;
        c_RUN: begin
          if (w_code != 3'd0) begin
            r_state <= c_FAULTED;
            r_fault <= 1'b1;
            r_code  <= w_code;
          end
        end
        default: r_state <= c_FAULTED;
      endcase
    end
  end

  assign PHASE      = r_phase;
  assign FAULT      = r_fault;
  assign FAULT_CODE = r_code;
  assign CYCLES     = r_cycles;

endmodule

`default_nettype wire

// File: tb/tb_traffic_light_monitor.sv
// ============================================================================
// tb_traffic_light_monitor: scoreboard bench for traffic_light_monitor.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_traffic_light_monitor;

  logic       CLK = 1'b0;
  logic       RESET, ENABLE, CLR;
  logic       GA, YA, RA, LA, GB, YB, RB, LB, GC, YC, RC, LC;
  logic       RL, GL, RR, GR;
  logic [1:0] PHASE;
  logic       FAULT;
  logic [2:0] FAULT_CODE;
  logic [7:0] CYCLES;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string      tag;
    logic [1:0] ph;
    logic       f;
    logic [2:0] code;
    logic [7:0] cyc;
  } exp_t;

  exp_t q[$];

  traffic_light_monitor dut (
    .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .CLR(CLR),
    .GA(GA), .YA(YA), .RA(RA), .LA(LA),
    .GB(GB), .YB(YB), .RB(RB), .LB(LB),
    .GC(GC), .YC(YC), .RC(RC), .LC(LC),
    .RL(RL), .GL(GL), .RR(RR), .GR(GR),
    .PHASE(PHASE), .FAULT(FAULT), .FAULT_CODE(FAULT_CODE), .CYCLES(CYCLES)
  );

  always #5 CLK = ~CLK;

  task automatic compare(input exp_t e);
    checks++;
    if ({PHASE, FAULT, FAULT_CODE, CYCLES} !== {e.ph, e.f, e.code, e.cyc}) begin
      failures++;
      $display("FAIL %s: got phase=%0d fault=%0d code=%0d cycles=%0d, want phase=%0d fault=%0d code=%0d cycles=%0d",
               e.tag, PHASE, FAULT, FAULT_CODE, CYCLES, e.ph, e.f, e.code, e.cyc);
    end
  endtask

  // Monitor: one registered result per clock edge.
  always @(posedge CLK) begin
    #1;
    if (q.size() > 0) compare(q.pop_front());
  end

  // Colour: 0 none (illegal), 1 G, 2 Y, 3 R.
  task automatic step(input string tag, input int ca, input int cb, input int cc,
                      input logic gl, input logic en, input logic clr,
                      input logic [1:0] ph, input logic f, input logic [2:0] code,
                      input logic [7:0] cyc);
    exp_t e;
    @(negedge CLK);
    GA = (ca == 1); YA = (ca == 2); RA = (ca == 3);
    GB = (cb == 1); YB = (cb == 2); RB = (cb == 3);
    GC = (cc == 1); YC = (cc == 2); RC = (cc == 3);
    GL = gl; RL = ~gl;
    ENABLE = en; CLR = clr;
    e.tag = tag; e.ph = ph; e.f = f; e.code = code; e.cyc = cyc;
    q.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t z;
    z.tag = "reset"; z.ph = 0; z.f = 0; z.code = 0; z.cyc = 0;
    RESET = 1'b0; ENABLE = 1'b0; CLR = 1'b0;
    LA = 0; LB = 0; LC = 0; GR = 0; RR = 1;
    GA = 0; YA = 0; RA = 1; GB = 0; YB = 0; RB = 1; GC = 0; YC = 0; RC = 1; GL = 0; RL = 1;
    #1 compare(z);
    repeat (2) @(negedge CLK);
    RESET = 1'b1;

    // Legal rotation A -> B -> C -> A
    step("rot_idle", 3,3,3, 0,1,0, 0,0,0,0);
    step("rot_arm",  3,3,3, 0,1,0, 0,0,0,0);
    step("rot_ag1",  1,3,3, 0,1,0, 1,0,0,1);
    step("rot_ag2",  1,3,3, 0,1,0, 1,0,0,1);
    step("rot_ag3",  1,3,3, 0,1,0, 1,0,0,1);
    step("rot_ay",   2,3,3, 0,1,0, 1,0,0,1);
    step("rot_ar",   3,3,3, 0,1,0, 0,0,0,1);
    step("rot_bg1",  3,1,3, 0,1,0, 2,0,0,1);
    step("rot_bg2",  3,1,3, 0,1,0, 2,0,0,1);
    step("rot_by",   3,2,3, 0,1,0, 2,0,0,1);
    step("rot_br",   3,3,3, 0,1,0, 0,0,0,1);
    step("rot_cg1",  3,3,1, 0,1,0, 3,0,0,1);
    step("rot_cg2",  3,3,1, 0,1,0, 3,0,0,1);
    step("rot_cy",   3,3,2, 0,1,0, 3,0,0,1);
    step("rot_cr",   3,3,3, 0,1,0, 0,0,0,1);
    step("rot_ag",   1,3,3, 0,1,0, 1,0,0,2);
    // Conflict, latched through legal samples
    step("conflict", 1,1,3, 0,1,0, 1,1,2,2);
    step("latch1",   1,3,3, 0,1,0, 1,1,2,2);
    step("latch2",   2,3,3, 0,1,0, 1,1,2,2);
    step("clr1",     3,3,3, 0,1,1, 1,0,0,2);
    step("c1_idle",  3,3,3, 0,1,0, 0,0,0,2);
    step("c1_arm",   3,3,3, 0,1,0, 0,0,0,2);
    // G->R directly
    step("bs_ag",    1,3,3, 0,1,0, 1,0,0,3);
    step("bad_seq",  3,3,3, 0,1,0, 0,1,3,3);
    step("clr2",     3,3,3, 0,1,1, 0,0,0,3);
    step("c2_idle",  3,3,3, 0,1,0, 0,0,0,3);
    step("c2_arm",   3,3,3, 0,1,0, 0,0,0,3);
    step("c2_run",   3,3,3, 0,1,0, 0,0,0,3);
    // Short green
    step("sg_ag",    1,3,3, 0,1,0, 1,0,0,4);
    step("short_g",  2,3,3, 0,1,0, 1,1,4,4);
    step("clr3",     3,3,3, 0,1,1, 1,0,0,4);
    step("c3_idle",  3,3,3, 0,1,0, 0,0,0,4);
    step("c3_arm",   3,3,3, 0,1,0, 0,0,0,4);
    step("c3_run",   3,3,3, 0,1,0, 0,0,0,4);
    // Pedestrian walk against B green
    step("pc_bg",    3,1,3, 0,1,0, 2,0,0,4);
    step("ped_conf", 3,1,3, 1,1,0, 2,1,6,4);
    step("clr4",     3,3,3, 0,1,1, 2,0,0,4);
    step("c4_idle",  3,3,3, 0,1,0, 0,0,0,4);
    step("c4_arm",   3,3,3, 0,1,0, 0,0,0,4);
    step("c4_run",   3,3,3, 0,1,0, 0,0,0,4);
    // ENABLE low mid-green freezes everything
    step("en_ag1",   1,3,3, 0,1,0, 1,0,0,5);
    for (int i = 0; i < 5; i++)
      step("en_hold", 3,3,3, 0,0,0, 1,0,0,5);
    step("en_ag2",   1,3,3, 0,1,0, 1,0,0,5);
    step("en_ag3",   1,3,3, 0,1,0, 1,0,0,5);
    step("en_ay",    2,3,3, 0,1,0, 1,0,0,5);

    // Asynchronous reset mid-yellow
    @(negedge CLK);
    ENABLE = 1'b0;
    RESET = 1'b0;
    #1 z.tag = "async_reset"; compare(z);
    @(negedge CLK);
    z.tag = "reset_hold"; compare(z);
    RESET = 1'b1;

    // No false BAD_SEQ after reset even though A was yellow before
    step("rr_idle",  1,3,3, 0,1,0, 1,0,0,0);
    step("rr_arm",   1,3,3, 0,1,0, 1,0,0,0);
    step("rr_run",   1,3,3, 0,1,0, 1,0,0,0);
    step("rr_ay",    2,3,3, 0,1,0, 1,0,0,0);
    step("rr_ar",    3,3,3, 0,1,0, 0,0,0,0);
    step("illegal",  0,3,3, 0,1,0, 0,1,1,0);
    step("clr5",     3,3,3, 0,1,1, 0,0,0,0);
    step("c5_idle",  3,3,3, 0,1,0, 0,0,0,0);
    step("c5_arm",   3,3,3, 0,1,0, 0,0,0,0);
    step("c5_run",   3,3,3, 0,1,0, 0,0,0,0);
    // Conflict and ped conflict together: lower code wins
    step("prio",     1,1,3, 1,1,0, 0,1,2,1);
    step("clr6",     3,3,3, 0,1,1, 0,0,0,1);

    // Long B green: stall only when the timeout feature is built
    for (int i = 1; i <= 15; i++)
      step("stall_pre", 3,1,3, 0,1,0, 2,0,0,1);
`ifdef TLM_TIMEOUT_EN
    step("stall",    3,1,3, 0,1,0, 2,1,7,1);
    step("stall_hold", 3,1,3, 0,1,0, 2,1,7,1);
`else
    step("no_stall", 3,1,3, 0,1,0, 2,0,0,1);
    step("no_stall2", 3,1,3, 0,1,0, 2,0,0,1);
`endif

    repeat (3) @(negedge CLK);
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expected results never checked, want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/traffic_light_monitor.md
Name: traffic_light_monitor

Overview:
- Receiving-end checker for the intersection controller's lamp outputs: three vehicle approaches A/B/C (green, yellow, red, left-arrow) and two pedestrian heads (L/R).
- Samples the lamp bus every enabled clock, tracks per-approach colour and dwell, and reports the current phase.
- Flags the first safety or sequencing violation with a sticky fault and code.
- Sits beside the controller in lab benches and on the board to drive a fault LED.

Parameters:
- MIN_GREEN, 2: minimum enabled cycles an approach must show G before Y.
- MIN_YELLOW, 1: minimum enabled cycles an approach must show Y before R.
- MAX_DWELL, 16: stall limit for the TLM_TIMEOUT_EN feature.
- CNT_W, 8: width of the dwell counters and CYCLES.

Ports:
- CLK input 1: system clock, rising edge.
- RESET input 1: asynchronous, active-low reset.
- ENABLE input 1: sample qualifier, same signal that drives the controller.
- CLR input 1: synchronous fault clear.
- GA,YA,RA,LA input 1 each: approach A green/yellow/red/left arrow.
- GB,YB,RB,LB input 1 each: approach B lamps.
- GC,YC,RC,LC input 1 each: approach C lamps.
- RL,GL input 1 each: left pedestrian red/walk.
- RR,GR input 1 each: right pedestrian red/walk.
- PHASE output 2: 0 all-red, 1 A, 2 B, 3 C (approach showing G, Y or L).
- FAULT output 1: sticky violation flag.
- FAULT_CODE output 3: code of the first violation.
- CYCLES output CNT_W: count of A entering G; saturates at all-ones.

Behaviour:
- RESET low, asynchronously: PHASE=0, FAULT=0, FAULT_CODE=0, CYCLES=0, all dwell counters=0, FSM=IDLE.
- Checks run only at rising edges with ENABLE=1. With ENABLE=0, all state holds and no checks run.
- Outputs are registered: a violation in the sample taken at edge k is visible after edge k.
- Monitor FSM:
  - IDLE: moves to ARM on the first enabled edge after reset or CLR.
  - ARM: captures the lamp state as "previous" with no sequence or dwell checks, then moves to RUN.
  - RUN: full checking.
  - FAULTED: entered on any violation. Lamp tracking and PHASE continue, but FAULT and FAULT_CODE freeze.
- Colour of an approach = the one of G/Y/R that is asserted.
- Violation codes, checked in RUN; when several occur in one sample, the lowest code wins:
  - 1 ILLEGAL: an approach does not have exactly one of G/Y/R, or has L together with Y; or a pedestrian pair does not have exactly one of R/G.
  - 2 CONFLICT: more than one approach is non-red (G, Y or L set).
  - 3 BAD_SEQ: illegal colour change. Legal changes are G->Y, Y->R, R->G, and no change. G->R, R->Y and Y->G are violations.
  - 4 SHORT_GREEN: at a G->Y change, green dwell < MIN_GREEN.
  - 5 SHORT_YELLOW: at a Y->R change, yellow dwell < MIN_YELLOW.
  - 6 PED_CONFLICT: GL or GR set while any approach shows G, Y or L.
  - 7 STALL: only with TLM_TIMEOUT_EN.
- Dwell counter, per approach: set to 1 on a colour change, otherwise incremented; saturates at all-ones. The sample that changes colour is checked against the pre-change dwell.
- PHASE: updated every enabled sample. With 0 or 1 non-red approaches it reflects that approach (0 if none). With 2 or more, PHASE holds its previous value.
- CYCLES: increments on an enabled R->G change of approach A. Saturates.
- CLR=1 at a clock edge: FAULT=0, FAULT_CODE=0, FSM=IDLE, dwell counters=0. CLR overrides ENABLE and any simultaneous violation. PHASE and CYCLES are kept.
- RESET mid-operation: everything returns to reset values immediately. The next enabled sample is an ARM sample, so no false BAD_SEQ.

Optional Feature:
- Macro: TLM_TIMEOUT_EN.
- Defined: in RUN, if any approach's dwell counter reaches MAX_DWELL, raise code 7 STALL. A stall in the same sample as codes 1–6 loses to them.
- Undefined: no stall check, code 7 never produced, and the stall comparators are not built.

Test Plan:
- Reset release, ENABLE=1, legal rotation A(G3,Y1,R) -> B -> C -> A: FAULT=0, PHASE sequence 1,2,3,1, CYCLES=2 after A re-enters G.
- GA and GB both high in one enabled sample (all else legal) -> FAULT=1, FAULT_CODE=2 after that edge; it stays latched through later legal samples.
- A goes G->R directly -> FAULT_CODE=3. Then CLR pulse -> FAULT=0. The next enabled sample (ARM) with A red raises no fault.
- A green for 1 cycle then Y, with MIN_GREEN=2 -> FAULT_CODE=4. In the same bench, GL=1 while GB=1 after CLR -> FAULT_CODE=6.
- ENABLE=0 for 5 cycles mid-green, then resume with total green dwell 3: no SHORT_GREEN, dwell counter frozen during ENABLE=0. Asserting RESET low mid-yellow -> all outputs 0 asynchronously.
- With TLM_TIMEOUT_EN defined and MAX_DWELL=16, hold A red / B green for 16 enabled cycles -> FAULT_CODE=7. Without the macro -> FAULT stays 0.
